// File: rtl/nn_pkg.sv
// Shared types for the neural-net datapath blocks.
// Data width and the layer buffer state encoding.
package nn_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        FILL,
        READY,
        REPLAY
    } lb_state_t;

endpackage

// File: rtl/layer_buffer_ram.sv
// DEPTH x DATA_W register array for the layer buffer.
// Synchronous write, registered read that holds when not enabled.
module layer_buffer_ram
    import nn_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Storage is deliberately left unreset; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/layer_buffer.sv
// Inter-layer activation buffer: captures one layer vector,
// then replays it on demand as a registered x stream.
module layer_buffer
    import nn_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] y_i,
    input  logic              y_v_i,
    input  logic              replay_i,
    input  logic              release_i,
    output logic [DATA_W-1:0] x_o,
    output logic              x_v_o,
    output logic              x_l_o,
    output logic              full_o,
    output logic              busy_o,
    output logic              ovf_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    lb_state_t     state_q, state_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic          x_v_q, x_v_d;
    logic          x_l_q, x_l_d;
    logic          busy_q, busy_d;
    logic          full_q, full_d;
    logic          ovf_q, ovf_d;
    logic          we;
    logic          re;

    layer_buffer_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (we),
        .waddr_i (wptr_q),
        .wdata_i (y_i),
        .re_i    (re),
        .raddr_i (rptr_q),
        .rdata_o (x_o)
    );

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        ovf_d   = ovf_q;
        we      = 1'b0;
        re      = 1'b0;
        unique case (state_q)
            FILL: begin
                if (y_v_i) begin
                    we = 1'b1;
                    if (wptr_q == LAST) begin
                        wptr_d  = '0;
                        state_d = READY;
                    end else begin
                        wptr_d = wptr_q + 1'b1;
                    end
                end
            end
            READY: begin
                if (y_v_i) begin
                    ovf_d = 1'b1;
                end
                if (replay_i) begin
                    rptr_d  = '0;
                    state_d = REPLAY;
                end else if (release_i) begin
                    state_d = FILL;
                end
            end
            REPLAY: begin
                if (y_v_i) begin
                    ovf_d = 1'b1;
                end
                // Address leads x_v by one cycle through the RAM read register.
                re = 1'b1;
                if (rptr_q == LAST) begin
                    rptr_d  = '0;
                    state_d = READY;
                end else begin
                    rptr_d = rptr_q + 1'b1;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
        x_v_d  = (state_q == REPLAY);
        x_l_d  = (state_q == REPLAY) && (rptr_q == LAST);
        busy_d = (state_q == REPLAY);
        // Held low while the final word of a pass is still on x.
        full_d = (state_d == READY) && (state_q != REPLAY);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
            wptr_q  <= '0;
            rptr_q  <= '0;
            x_v_q   <= 1'b0;
            x_l_q   <= 1'b0;
            busy_q  <= 1'b0;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            x_v_q   <= x_v_d;
            x_l_q   <= x_l_d;
            busy_q  <= busy_d;
            full_q  <= full_d;
            ovf_q   <= ovf_d;
        end
    end

    assign x_v_o  = x_v_q;
    assign x_l_o  = x_l_q;
    assign busy_o = busy_q;
    assign full_o = full_q;
    assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_layer_buffer.sv
// Directed bench for layer_buffer with DEPTH=4.
// Each task drives one scenario and checks against hand-computed values.
module tb_layer_buffer;

    logic        clk;
    logic        rst;
    logic [31:0] y_i;
    logic        y_v_i;
    logic        replay_i;
    logic        release_i;
    logic [31:0] x_o;
    logic        x_v_o;
    logic        x_l_o;
    logic        full_o;
    logic        busy_o;
    logic        ovf_o;

    int          checks;
    int          errors;
    logic [31:0] exp_w [4];

    layer_buffer #(
        .DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .y_i       (y_i),
        .y_v_i     (y_v_i),
        .replay_i  (replay_i),
        .release_i (release_i),
        .x_o       (x_o),
        .x_v_o     (x_v_o),
        .x_l_o     (x_l_o),
        .full_o    (full_o),
        .busy_o    (busy_o),
        .ovf_o     (ovf_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        y_i       = '0;
        y_v_i     = 1'b0;
        replay_i  = 1'b0;
        release_i = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        checks++;
        if ({x_v_o, x_l_o, full_o, busy_o, ovf_o} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_flags: got %b exp 00000",
                     {x_v_o, x_l_o, full_o, busy_o, ovf_o});
        end
        checks++;
        if (x_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_x: got %h exp 0", x_o);
        end
    endtask

    task automatic fill(input string tag);
        for (int i = 0; i < 4; i++) begin
            y_i   = exp_w[i];
            y_v_i = 1'b1;
            step();
            checks++;
            if ({x_v_o, full_o, busy_o, ovf_o} !== {1'b0, (i == 3), 2'b00}) begin
                errors++;
                $display("FAIL %s_fill%0d: xv/full/busy/ovf got %b exp %b",
                         tag, i, {x_v_o, full_o, busy_o, ovf_o},
                         {1'b0, (i == 3), 2'b00});
            end
        end
        y_v_i = 1'b0;
    endtask

    task automatic start_replay(input string tag);
        replay_i = 1'b1;
        step();
        replay_i = 1'b0;
        checks++;
        if ({x_v_o, busy_o, full_o} !== 3'b000) begin
            errors++;
            $display("FAIL %s_start: xv/busy/full got %b exp 000",
                     tag, {x_v_o, busy_o, full_o});
        end
    endtask

    task automatic pass_body(input string tag, input bit chain);
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if ({x_v_o, x_l_o, busy_o, full_o} !== {1'b1, (k == 3), 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL %s_flags%0d: xv/xl/busy/full got %b exp %b",
                         tag, k, {x_v_o, x_l_o, busy_o, full_o},
                         {1'b1, (k == 3), 1'b1, 1'b0});
            end
            checks++;
            if (x_o !== exp_w[k]) begin
                errors++;
                $display("FAIL %s_x%0d: got %h exp %h", tag, k, x_o, exp_w[k]);
            end
        end
        replay_i = chain;
        step();
        replay_i = 1'b0;
        checks++;
        if ({x_v_o, x_l_o, busy_o, full_o} !== {3'b000, !chain}) begin
            errors++;
            $display("FAIL %s_end: xv/xl/busy/full got %b exp %b",
                     tag, {x_v_o, x_l_o, busy_o, full_o}, {3'b000, !chain});
        end
        checks++;
        if (x_o !== exp_w[3]) begin
            errors++;
            $display("FAIL %s_hold: got %h exp %h", tag, x_o, exp_w[3]);
        end
    endtask

    task automatic test_fill();
        exp_w = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
        fill("f");
    endtask

    task automatic test_single_replay();
        start_replay("single");
        pass_body("single", 1'b0);
    endtask

    task automatic test_back_to_back();
        start_replay("b2b");
        pass_body("b2b_p1", 1'b1);
        pass_body("b2b_p2", 1'b1);
        pass_body("b2b_p3", 1'b0);
    endtask

    task automatic test_release_refill();
        release_i = 1'b1;
        step();
        release_i = 1'b0;
        checks++;
        if (full_o !== 1'b0) begin
            errors++;
            $display("FAIL release_full: got %b exp 0", full_o);
        end
        exp_w = '{32'h1, 32'h2, 32'h3, 32'h4};
        fill("refill");
        start_replay("refill");
        pass_body("refill", 1'b0);
    endtask

    task automatic test_replay_release();
        replay_i  = 1'b1;
        release_i = 1'b1;
        step();
        replay_i  = 1'b0;
        release_i = 1'b0;
        checks++;
        if ({x_v_o, busy_o, full_o} !== 3'b000) begin
            errors++;
            $display("FAIL both_start: xv/busy/full got %b exp 000",
                     {x_v_o, busy_o, full_o});
        end
        pass_body("both", 1'b0);
        step();
        checks++;
        if (full_o !== 1'b1) begin
            errors++;
            $display("FAIL both_still_full: got %b exp 1", full_o);
        end
    endtask

    task automatic test_ovf();
        replay_i = 1'b1;
        step();
        replay_i = 1'b0;
        y_i   = 32'hDEADBEEF;
        y_v_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            y_v_i = 1'b0;
            checks++;
            if ({x_v_o, ovf_o} !== 2'b11 || x_o !== exp_w[k]) begin
                errors++;
                $display("FAIL ovf_pass%0d: xv/ovf got %b x %h exp 11 x %h",
                         k, {x_v_o, ovf_o}, x_o, exp_w[k]);
            end
        end
        step();
        checks++;
        if ({full_o, ovf_o} !== 2'b11) begin
            errors++;
            $display("FAIL ovf_after: full/ovf got %b exp 11", {full_o, ovf_o});
        end
        start_replay("ovf_re");
        pass_body("ovf_re", 1'b0);
        checks++;
        if (ovf_o !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: got %b exp 1", ovf_o);
        end
    endtask

    task automatic test_reset_mid();
        start_replay("rmid");
        step();
        step();
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({x_v_o, x_l_o, busy_o, full_o, ovf_o} !== 5'b00000) begin
            errors++;
            $display("FAIL rmid_async: xv/xl/busy/full/ovf got %b exp 00000",
                     {x_v_o, x_l_o, busy_o, full_o, ovf_o});
        end
        checks++;
        if (x_o !== 32'h0) begin
            errors++;
            $display("FAIL rmid_x: got %h exp 0", x_o);
        end
        step();
        step();
        rst   = 1'b0;
        y_i   = 32'hAA;
        y_v_i = 1'b1;
        step();
        y_i = 32'hBB;
        step();
        y_v_i    = 1'b0;
        replay_i = 1'b1;
        step();
        replay_i = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            checks++;
            if ({x_v_o, busy_o, full_o, ovf_o} !== 4'b0000) begin
                errors++;
                $display("FAIL rmid_noout%0d: xv/busy/full/ovf got %b exp 0000",
                         k, {x_v_o, busy_o, full_o, ovf_o});
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_fill();
        test_single_replay();
        test_back_to_back();
        test_release_refill();
        test_replay_release();
        test_ovf();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
